// File: rtl/slew_rate_detector.sv
// Slew-rate detector: per-sample difference of a signed audio stream, with
// hysteretic detection of sustained slewing. Optional peak meter: SLEW_DETECT_PEAK_EN.
module slew_rate_detector #(
  parameter int unsigned VCC             = 12,
  parameter int unsigned SAMPLE_RATE     = 48000,
  parameter int unsigned MAX_CHANGE_RATE = 1000,
  parameter int unsigned ENTER_COUNT     = 4,
  parameter int unsigned EXIT_COUNT      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic signed [15:0] rate,
  output logic               slewing,
  output logic               slew_dir,
  output logic        [15:0] event_count
`ifdef SLEW_DETECT_PEAK_EN
  ,
  input  logic               peak_clear,
  output logic        [15:0] peak_rate
`endif
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DIFF_W  = DATA_W + 1;
  localparam int unsigned CNT_MAX = (ENTER_COUNT > EXIT_COUNT) ? ENTER_COUNT : EXIT_COUNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Same threshold formula as the limiters, truncating after each divide.
  localparam logic [63:0] THRESH =
    ((64'(MAX_CHANGE_RATE) << 14) / 64'(VCC)) / 64'(SAMPLE_RATE);

  localparam logic [CNT_W-1:0] ENTER_LAST = CNT_W'(ENTER_COUNT);
  localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    SLEWING   = 2'd2,
    RELEASING = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                primed_q, primed_d;
  logic [DATA_W-1:0]   rate_q, rate_d;
  logic                slewing_q, slewing_d;
  logic                dir_q, dir_d;
  logic [DATA_W-1:0]   evc_q, evc_d;

  logic signed [DIFF_W-1:0] diff_c;
  logic [DIFF_W-1:0]        abs_c;
  logic [DATA_W-1:0]        rate_sat_c;
  logic                     exceed_c;
  logic                     dir_c;
  logic [DATA_W-1:0]        evc_inc_c;
  logic [CNT_W-1:0]         cnt_inc_c;

  // Sample datapath: 17-bit difference, magnitude, clamp, threshold compare.
  always_comb begin
    diff_c = {in[DATA_W-1], in} - {prev_q[DATA_W-1], prev_q};
    abs_c  = diff_c[DIFF_W-1] ? DIFF_W'(-diff_c) : DIFF_W'(diff_c);
    if (diff_c[DIFF_W-1] != diff_c[DIFF_W-2]) begin
      rate_sat_c = diff_c[DIFF_W-1] ? 16'h8000 : 16'h7FFF;
    end else begin
      rate_sat_c = diff_c[DATA_W-1:0];
    end
    exceed_c  = 64'(abs_c) > THRESH;
    dir_c     = !diff_c[DIFF_W-1] && (diff_c != '0);
    evc_inc_c = (evc_q == 16'hFFFF) ? evc_q : evc_q + 16'd1;
    cnt_inc_c = cnt_q + CNT_ONE;
  end

  // Next-state logic; the FSM moves only on strobes once prev holds a real sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    primed_d  = primed_q;
    rate_d    = rate_q;
    dir_d     = dir_q;
    evc_d     = evc_q;

    if (audio_clk_en) begin
      prev_d   = in;
      primed_d = 1'b1;
      if (primed_q) begin
        rate_d = rate_sat_c;
        unique case (state_q)
          IDLE: begin
            if (exceed_c) begin
              dir_d = dir_c;
              if (ENTER_COUNT == 1) begin
                state_d = SLEWING;
                evc_d   = evc_inc_c;
                cnt_d   = '0;
              end else begin
                state_d = ARMING;
                cnt_d   = CNT_ONE;
              end
            end
          end
          ARMING: begin
            if (!exceed_c) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (dir_c != dir_q) begin
              cnt_d = CNT_ONE;
              dir_d = dir_c;
            end else if (cnt_inc_c == ENTER_LAST) begin
              state_d = SLEWING;
              evc_d   = evc_inc_c;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end
          SLEWING: begin
            if (exceed_c) begin
              dir_d = dir_c;
            end else if (EXIT_COUNT == 1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASING;
              cnt_d   = CNT_ONE;
            end
          end
          RELEASING: begin
            if (exceed_c) begin
              state_d = SLEWING;
              dir_d   = dir_c;
              cnt_d   = '0;
            end else if (cnt_inc_c == EXIT_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    slewing_d = (state_d == SLEWING) || (state_d == RELEASING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= '0;
      primed_q  <= 1'b0;
      rate_q    <= '0;
      slewing_q <= 1'b0;
      dir_q     <= 1'b0;
      evc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      rate_q    <= rate_d;
      slewing_q <= slewing_d;
      dir_q     <= dir_d;
      evc_q     <= evc_d;
    end
  end

  assign rate        = rate_q;
  assign slewing     = slewing_q;
  assign slew_dir    = dir_q;
  assign event_count = evc_q;

`ifdef SLEW_DETECT_PEAK_EN
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [DATA_W-1:0] abs_sat_c;
  logic [DATA_W-1:0] peak_base_c;

  // Clear and a coincident strobe combine: the strobe's magnitude becomes the new peak.
  always_comb begin
    abs_sat_c   = abs_c[DIFF_W-1] ? 16'hFFFF : abs_c[DATA_W-1:0];
    peak_base_c = peak_clear ? '0 : peak_q;
    peak_d      = peak_base_c;
    if (audio_clk_en && primed_q && (abs_sat_c > peak_base_c)) begin
      peak_d = abs_sat_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_rate = peak_q;
`endif

endmodule

// File: tb/tb_slew_rate_detector.sv
// Self-checking bench for slew_rate_detector: vector table driven through a
// scoreboard queue, plus hand-written reset and peak sequences.
module tb_slew_rate_detector;

  typedef struct packed {
    logic [15:0] din;
    logic [15:0] rate;
    logic        sl;
    logic        dir;
    logic [15:0] evc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] rate;
  logic        slewing;
  logic        slew_dir;
  logic [15:0] event_count;
`ifdef SLEW_DETECT_PEAK_EN
  logic        peak_clear = 1'b0;
  logic [15:0] peak_rate;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  slew_rate_detector dut (
    .clk         (clk),
    .reset       (reset),
    .audio_clk_en(en),
    .in          (din),
    .rate        (rate),
    .slewing     (slewing),
    .slew_dir    (slew_dir),
    .event_count (event_count)
`ifdef SLEW_DETECT_PEAK_EN
    ,
    .peak_clear  (peak_clear),
    .peak_rate   (peak_rate)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp_v);
    end
  endtask

  function automatic void add(input logic [15:0] d, input logic [15:0] r,
                              input logic s, input logic dr, input logic [15:0] e);
    vec_t v;
    v.din = d; v.rate = r; v.sl = s; v.dir = dr; v.evc = e;
    vecs.push_back(v);
  endfunction

  task automatic compare_outputs(input string tag, input vec_t e);
    check({tag, " rate"},    rate,              e.rate);
    check({tag, " slewing"}, 16'(slewing),      16'(e.sl));
    check({tag, " dir"},     16'(slew_dir),     16'(e.dir));
    check({tag, " evc"},     event_count,       e.evc);
  endtask

  // Each strobe pushes its expectation; the result one clock later pops it.
  task automatic apply_all();
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      din = vecs[i].din;
      en  = 1'b1;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      en = 1'b0;
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d queue", i), 16'd0, 16'd1);
      end else begin
        e = exp_q.pop_front();
        compare_outputs($sformatf("v%0d", i), e);
        if (i % 4 == 3) begin
          @(posedge clk);
          #1;
          compare_outputs($sformatf("v%0d hold", i), e);
        end
      end
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset rate",    rate,             16'd0);
    check("reset slewing", 16'(slewing),     16'd0);
    check("reset dir",     16'(slew_dir),    16'd0);
    check("reset evc",     event_count,      16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Priming, entry on the 4th exceeding step, then release after 16 quiet samples.
    add(16'd1000, 16'd0,  1'b0, 1'b0, 16'd0);
    add(16'd1010, 16'd10, 1'b0, 1'b0, 16'd0);
    add(16'd1040, 16'd30, 1'b0, 1'b1, 16'd0);
    add(16'd1070, 16'd30, 1'b0, 1'b1, 16'd0);
    add(16'd1100, 16'd30, 1'b0, 1'b1, 16'd0);
    add(16'd1130, 16'd30, 1'b1, 1'b1, 16'd1);
    for (int k = 0; k < 15; k++) add(16'd1130, 16'd0, 1'b1, 1'b1, 16'd1);
    add(16'd1130, 16'd0, 1'b0, 1'b1, 16'd1);
    // Re-enter, then an exceeding sample on the 10th quiet one returns to SLEWING.
    add(16'd1160, 16'd30, 1'b0, 1'b1, 16'd1);
    add(16'd1190, 16'd30, 1'b0, 1'b1, 16'd1);
    add(16'd1220, 16'd30, 1'b0, 1'b1, 16'd1);
    add(16'd1250, 16'd30, 1'b1, 1'b1, 16'd2);
    for (int k = 0; k < 9; k++) add(16'd1250, 16'd0, 1'b1, 1'b1, 16'd2);
    add(16'd1280, 16'd30, 1'b1, 1'b1, 16'd2);
    for (int k = 0; k < 15; k++) add(16'd1280, 16'd0, 1'b1, 1'b1, 16'd2);
    add(16'd1280, 16'd0, 1'b0, 1'b1, 16'd2);
    // Exactly at threshold: never exceeds.
    for (int k = 1; k <= 6; k++) add(16'(1280 + 28 * k), 16'd28, 1'b0, 1'b1, 16'd2);
    // Direction flip while arming restarts the count.
    add(16'd1478, 16'd30,    1'b0, 1'b1, 16'd2);
    add(16'd1508, 16'd30,    1'b0, 1'b1, 16'd2);
    add(16'd1478, 16'hFFE2,  1'b0, 1'b0, 16'd2);
    add(16'd1448, 16'hFFE2,  1'b0, 1'b0, 16'd2);
    add(16'd1418, 16'hFFE2,  1'b0, 1'b0, 16'd2);
    add(16'd1388, 16'hFFE2,  1'b1, 1'b0, 16'd3);
    // Full-scale steps saturate the rate output.
    add(16'h8000, 16'h8000, 1'b1, 1'b0, 16'd3);
    add(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 16'd3);
    add(16'h8000, 16'h8000, 1'b1, 1'b0, 16'd3);
    apply_all();

`ifdef SLEW_DETECT_PEAK_EN
    check("peak full scale", peak_rate, 16'hFFFF);
    @(negedge clk);
    peak_clear = 1'b1;
    @(negedge clk);
    peak_clear = 1'b0;
    check("peak cleared", peak_rate, 16'd0);
`endif

    // Asynchronous reset between strobes while slewing.
    check("pre-reset slewing", 16'(slewing), 16'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async rate",    rate,          16'd0);
    check("async slewing", 16'(slewing),  16'd0);
    check("async dir",     16'(slew_dir), 16'd0);
    check("async evc",     event_count,   16'd0);
    @(negedge clk);
    reset = 1'b0;

    vecs.delete();
    add(16'd5000, 16'd0,  1'b0, 1'b0, 16'd0);
    add(16'd5010, 16'd10, 1'b0, 1'b0, 16'd0);
    add(16'd5040, 16'd30, 1'b0, 1'b1, 16'd0);
    apply_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
